// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the pipelined multi-cycle ALU:
//   - opcode localparams ([3]=A invert, [2]=B invert, [1:0]=function)
//   - FSM state encoding for the handshake/iterator in alu_pipe_mc
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational WIDTH-bit logic/add/SLT datapath.
//   Ports:
//     a, b      in   WIDTH  operands
//     op        in   4      opcode (see alu_pkg)
//     result    out  WIDTH  logic/arithmetic result (0 for unknown opcodes)
//     cout      out  1      carry out of the MSB for ADD/SUB/SLT, else 0
//     overflow  out  1      signed overflow for ADD/SUB/SLT, else 0
//   MUL is not handled here; it decodes as "unknown" and yields zeros.
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  // Signed overflow of x + y = s: operands agree in sign, sum disagrees.
  function automatic logic add_ovf(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] s
  );
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] a_eff;
  logic signed [WIDTH-1:0] b_eff;
  logic signed [WIDTH-1:0] sum;
  logic                    carry;
  logic                    ovf;

  always_comb begin
    a_eff = op[3] ? ~a : a;
    b_eff = op[2] ? ~b : b;
    // B-invert doubles as carry-in so SUB/SLT become A + ~B + 1.
    {carry, sum} = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};
    ovf = add_ovf(a_eff, b_eff, sum);

    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND, OP_NOR: result = a_eff & b_eff;
      OP_OR:          result = a_eff | b_eff;
      OP_ADD, OP_SUB: begin
        result   = sum;
        cout     = carry;
        overflow = ovf;
      end
      OP_SLT: begin
        // Correcting the sign with the overflow bit keeps SLT exact.
        result   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        cout     = carry;
        overflow = ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_pipe_mc.sv
// ---------------------------------------------------------------------------
// alu_pipe_mc
//   Valid/ready wrapped ALU with registered result/flags and an iterative
//   shift-add multiplier. Holds exactly one operation in flight.
//   Ports:
//     clk, rst      clock (rising edge) and synchronous active-high reset
//     in_valid      operation presented on src1/src2/ALU_control
//     in_ready      operation accepted this cycle when in_valid is also high
//     src1, src2    operands A and B (WIDTH)
//     ALU_control   4-bit opcode, captured on accept
//     out_valid     result and flags valid
//     out_ready     consumer takes the result this cycle
//     result        registered result (WIDTH)
//     zero          result == 0
//     cout          carry / unsigned-overflow flag
//     overflow      signed overflow flag
//     busy          a MUL is iterating
//   Single-cycle ops have latency 1; MUL (MUL_EN=1) has latency WIDTH+1.
// ---------------------------------------------------------------------------
module alu_pipe_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic               vld_p1;
  logic [WIDTH-1:0]   result_p1;
  logic               zero_p1;
  logic               cout_p1;
  logic               ovf_p1;

  logic [2*WIDTH-1:0] mul_a_p0;
  logic [WIDTH-1:0]   mul_b_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [CW-1:0]      cnt_p0;

  logic [WIDTH-1:0]   core_result;
  logic               core_cout;
  logic               core_ovf;

  logic               accept;
  logic               take;
  logic               is_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] acc_nxt;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (src1),
    .b        (src2),
    .op       (ALU_control),
    .result   (core_result),
    .cout     (core_cout),
    .overflow (core_ovf)
  );

  assign in_ready = !rst && (state == ST_IDLE) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = vld_p1 && out_ready;
  assign is_mul   = MUL_EN && (ALU_control == OP_MUL);

  // Partial product for this iteration; the full 2*WIDTH product is kept so
  // the high half can drive cout.
  assign acc_nxt  = acc_p0 + (mul_b_p0[0] ? mul_a_p0 : '0);
  // Decrement from 1 reaches 0 on this edge: the last partial product.
  assign mul_last = (cnt_p0 == CW'(1));

  // ---- stage p0: multiplier operand/accumulator registers (data only) ----
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (accept && is_mul) begin
        mul_a_p0 <= {{WIDTH{1'b0}}, src1};
        mul_b_p0 <= src2;
        acc_p0   <= '0;
      end
    end else begin
      acc_p0   <= acc_nxt;
      mul_a_p0 <= mul_a_p0 << 1;
      mul_b_p0 <= mul_b_p0 >> 1;
    end
  end

  // ---- stage p1: FSM, counter and registered result/flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vld_p1    <= 1'b0;
      cnt_p0    <= '0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      cout_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state  <= ST_MUL;
              vld_p1 <= 1'b0;
              cnt_p0 <= CW'(WIDTH);
            end else begin
              vld_p1    <= 1'b1;
              result_p1 <= core_result;
              zero_p1   <= (core_result == '0);
              cout_p1   <= core_cout;
              ovf_p1    <= core_ovf;
            end
          end else if (take) begin
            vld_p1 <= 1'b0;
          end
        end
        ST_MUL: begin
          cnt_p0 <= cnt_p0 - CW'(1);
          if (mul_last) begin
            state     <= ST_IDLE;
            vld_p1    <= 1'b1;
            result_p1 <= acc_nxt[WIDTH-1:0];
            zero_p1   <= (acc_nxt[WIDTH-1:0] == '0);
            cout_p1   <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_p1    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign zero      = zero_p1;
  assign cout      = cout_p1;
  assign overflow  = ovf_p1;
  assign busy      = (state == ST_MUL);

endmodule
